// File: rtl/instr_sequencer_pkg.sv
// Shared types for the autoencoder program sequencer:
// FSM states, opcode map and decoded instruction classes.
package instr_sequencer_pkg;

  localparam int OPC_W = 4;
  localparam int ARG_W = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_EXEC,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_MAC   = 4'h2,
    OP_ACT   = 4'h3,
    OP_STORE = 4'h4,
    OP_JMP   = 4'h8,
    OP_SETL  = 4'h9,
    OP_DJNZ  = 4'hA,
    OP_HALT  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    K_NOP,
    K_DP,
    K_JMP,
    K_SETL,
    K_DJNZ,
    K_HALT,
    K_ILL
  } kind_e;

  function automatic logic is_dp(
    input logic [OPC_W-1:0] op
  );
    return (op == OP_LOAD) || (op == OP_MAC) ||
           (op == OP_ACT)  || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Datapath op channel: valid/ready offer of an op,
// then a one-cycle done pulse when the op completes.
interface instr_sequencer_if
  import instr_sequencer_pkg::*;
();

  logic             op_valid;
  logic [OPC_W-1:0] op_code;
  logic [ARG_W-1:0] op_arg;
  logic             op_ready;
  logic             op_done;

  modport master (
    output op_valid,
    output op_code,
    output op_arg,
    input  op_ready,
    input  op_done
  );

  modport slave (
    input  op_valid,
    input  op_code,
    input  op_arg,
    output op_ready,
    output op_done
  );

endinterface

// File: rtl/instr_sequencer_dec.sv
// Classifies the opcode nibble of an instruction word
// into the control/datapath class the sequencer acts on.
module instr_sequencer_dec
  import instr_sequencer_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output kind_e            kind
);

  always_comb begin
    kind = K_ILL;
    unique case (1'b1)
      opcode == OP_NOP:  kind = K_NOP;
      is_dp(opcode):     kind = K_DP;
      opcode == OP_JMP:  kind = K_JMP;
      opcode == OP_SETL: kind = K_SETL;
      opcode == OP_DJNZ: kind = K_DJNZ;
      opcode == OP_HALT: kind = K_HALT;
      default:           kind = K_ILL;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: fetches from a 1-cycle ROM, runs control
// flow locally and hands datapath ops out over dp.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
  parameter int LOOP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] instr,
  instr_sequencer_if.master     dp,
  output logic                  busy,
  output logic                  halted,
  output logic                  error
);

  state_e                state;
  kind_e                 kind;
  logic [LOOP_WIDTH-1:0] loop_cnt;
  logic                  op_valid_q;
  logic [OPC_W-1:0]      op_code_q;
  logic [ARG_W-1:0]      op_arg_q;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] target;

  instr_sequencer_dec u_dec (
    .opcode (instr[15:12]),
    .kind   (kind)
  );

  assign pc_inc = pc + 1'b1;
  assign target = instr[ADDR_WIDTH-1:0];

  assign dp.op_valid = op_valid_q;
  assign dp.op_code  = op_code_q;
  assign dp.op_arg   = op_arg_q;

  assign busy   = (state != S_IDLE) &&
                  (state != S_HALT);
  assign halted = (state == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= START_ADDR;
      loop_cnt   <= '0;
      op_valid_q <= 1'b0;
      op_code_q  <= '0;
      op_arg_q   <= '0;
      error      <= 1'b0;
    end else if (abort) begin
      // loop_cnt survives abort on purpose
      state      <= S_IDLE;
      pc         <= START_ADDR;
      op_valid_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state <= S_FETCH;
            pc    <= START_ADDR;
            error <= 1'b0;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          state <= S_FETCH;
          case (kind)
            K_NOP:  pc <= pc_inc;
            K_JMP:  pc <= target;
            K_SETL: begin
              loop_cnt <= instr[LOOP_WIDTH-1:0];
              pc       <= pc_inc;
            end
            K_DJNZ: begin
              if (loop_cnt != '0) begin
                loop_cnt <= loop_cnt - 1'b1;
                pc       <= target;
              end else begin
                pc <= pc_inc;
              end
            end
            K_HALT: state <= S_HALT;
            K_DP: begin
              op_code_q  <= instr[15:12];
              op_arg_q   <= instr[11:0];
              op_valid_q <= 1'b1;
              state      <= S_ISSUE;
            end
            default: begin
              error <= 1'b1;
              state <= S_HALT;
            end
          endcase
        end
        S_ISSUE: begin
          if (dp.op_ready) begin
            op_valid_q <= 1'b0;
            if (dp.op_done) begin
              pc    <= pc_inc;
              state <= S_FETCH;
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (dp.op_done) begin
            pc    <= pc_inc;
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
